// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port and backing-memory bus seen by the arbiter.
// The arbiter takes the slave view; the core/memory environment takes the master view.
interface unified_mem_arbiter_if;
    // Instruction-fetch requester
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_err;
    logic [31:0] i_rdata;
    // Data-access requester
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_type;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_err;
    logic [31:0] d_rdata;
    // Backing memory
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_err, i_rdata,
        input  d_req, d_we, d_type, d_addr, d_wdata,
        output d_ready, d_err, d_rdata,
        output mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_err, i_rdata,
        output d_req, d_we, d_type, d_addr, d_wdata,
        input  d_ready, d_err, d_rdata,
        input  mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports.
// Data wins ties, but after D_MAX_CONSEC back-to-back data grants with a fetch waiting
// the fetch is served. A watchdog aborts transactions that never see mem_ack.
module unified_mem_arbiter #(
    parameter int unsigned D_MAX_CONSEC   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [2:0]  FETCH_TYPE     = 3'b010
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StRespI,
        StRespD
    } state_e;

    state_e      state_q;
    logic [7:0]  consec_q;
    logic [15:0] wdog_q;

    logic        d_grant;
    logic [7:0]  consec_inc;
    logic        wdog_expired;

    // Grant qualification, saturating streak increment and watchdog limit detect.
    always_comb begin
        d_grant      = bus_io.d_req &&
                       (!bus_io.i_req || (32'(consec_q) < D_MAX_CONSEC));
        consec_inc   = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
        // Expires on the BUSY cycle that would bring the count up to the limit.
        wdog_expired = ((32'(wdog_q) + 32'd1) >= TIMEOUT_CYCLES);
    end

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            consec_q         <= '0;
            wdog_q           <= '0;
            bus_io.mem_req   <= 1'b0;
            bus_io.mem_we    <= 1'b0;
            bus_io.mem_type  <= '0;
            bus_io.mem_addr  <= '0;
            bus_io.mem_wdata <= '0;
            bus_io.i_ready   <= 1'b0;
            bus_io.i_err     <= 1'b0;
            bus_io.i_rdata   <= '0;
            bus_io.d_ready   <= 1'b0;
            bus_io.d_err     <= 1'b0;
            bus_io.d_rdata   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (d_grant) begin
                        state_q          <= StBusyD;
                        // Streak only counts while a fetch is actually waiting.
                        consec_q         <= bus_io.i_req ? consec_inc : 8'd0;
                        bus_io.mem_req   <= 1'b1;
                        bus_io.mem_we    <= bus_io.d_we;
                        bus_io.mem_type  <= bus_io.d_type;
                        bus_io.mem_addr  <= bus_io.d_addr;
                        bus_io.mem_wdata <= bus_io.d_wdata;
                    end else if (bus_io.i_req) begin
                        state_q         <= StBusyI;
                        consec_q        <= '0;
                        bus_io.mem_req  <= 1'b1;
                        bus_io.mem_we   <= 1'b0;
                        bus_io.mem_type <= FETCH_TYPE;
                        bus_io.mem_addr <= bus_io.i_addr;
                    end
                end
                StBusyI, StBusyD: begin
                    if (bus_io.mem_ack) begin
                        bus_io.mem_req <= 1'b0;
                        wdog_q         <= '0;
                        if (state_q == StBusyI) begin
                            state_q        <= StRespI;
                            bus_io.i_ready <= 1'b1;
                            bus_io.i_rdata <= bus_io.mem_rdata;
                        end else begin
                            state_q        <= StRespD;
                            bus_io.d_ready <= 1'b1;
                            if (!bus_io.mem_we) begin
                                bus_io.d_rdata <= bus_io.mem_rdata;
                            end
                        end
                    end else if (wdog_expired) begin
                        // Abort: complete with error, read data left untouched.
                        bus_io.mem_req <= 1'b0;
                        wdog_q         <= '0;
                        if (state_q == StBusyI) begin
                            state_q        <= StRespI;
                            bus_io.i_ready <= 1'b1;
                            bus_io.i_err   <= 1'b1;
                        end else begin
                            state_q        <= StRespD;
                            bus_io.d_ready <= 1'b1;
                            bus_io.d_err   <= 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                StRespI, StRespD: begin
                    // No grant here: the finishing requester still holds req this cycle.
                    state_q        <= StIdle;
                    bus_io.i_ready <= 1'b0;
                    bus_io.i_err   <= 1'b0;
                    bus_io.d_ready <= 1'b0;
                    bus_io.d_err   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates the core's instruction-fetch port and data-access port onto one single-ported backing memory with a request/acknowledge interface of variable latency. Data accesses have priority, with a starvation guard that caps back-to-back data grants while a fetch is waiting. Each requester gets a one-cycle ready pulse on completion, and its stall logic holds the pipeline until that pulse. A watchdog aborts any memory transaction that is never acknowledged.

## Interface
- D_MAX_CONSEC, 4: maximum consecutive data grants while i_req is pending; range 1–255.
- TIMEOUT_CYCLES, 255: BUSY cycles without mem_ack before abort; range 1–65535.
- FETCH_TYPE, 3'b010: value driven on mem_type during fetches (word access).

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  32  fetch address; stable while i_req is high.
- i_ready  out  1  one-cycle completion pulse for a fetch.
- i_err  out  1  high with i_ready when the fetch timed out.
- i_rdata  out  32  fetched word; held until the next fetch completes.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_type  in  3  load/store type; passed to mem_type.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle completion pulse for a data access.
- d_err  out  1  high with d_ready when the data access timed out.
- d_rdata  out  32  load data; held until the next load completes.
- mem_req  out  1  memory request; held until mem_ack or abort.
- mem_we  out  1  memory write enable.
- mem_type  out  3  access type.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read data.

## Operation
- States:
  - IDLE
  - BUSY_I
  - BUSY_D
  - RESP_I
  - RESP_D
- Every output is a register.
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, i_ready, d_ready, i_err and d_err are 0.
  - mem_addr, mem_wdata, mem_type, i_rdata and d_rdata are 0.
  - The consecutive-data counter and the watchdog are 0.
- IDLE grant decision, made in priority order:
  - d_req=1 and (i_req=0 or consec < D_MAX_CONSEC) → BUSY_D.
  - i_req=1 → BUSY_I.
  - Otherwise stay in IDLE.
- Consecutive-data counter:
  - On a data grant with i_req=1, consec increments, saturating at 255.
  - On a data grant with i_req=0, consec clears.
  - On a fetch grant, consec clears.
- Entering BUSY_I:
  - mem_req=1, mem_we=0, mem_type=FETCH_TYPE, mem_addr=i_addr.
- Entering BUSY_D:
  - mem_req=1, mem_we=d_we, mem_type=d_type, mem_addr=d_addr, mem_wdata=d_wdata.
- Requester inputs are sampled only at the grant edge. Changes during BUSY are ignored.
- BUSY_x with mem_ack=1:
  - mem_req drops to 0 and the watchdog clears.
  - The state moves to RESP_x.
  - x_ready is set for one cycle.
  - For a fetch or a load, x_rdata captures mem_rdata. d_rdata is unchanged on stores.
- BUSY_x with mem_ack=0:
  - The watchdog increments.
  - When it reaches TIMEOUT_CYCLES: mem_req drops, the state moves to RESP_x, x_ready=1, x_err=1, x_rdata is unchanged, and the watchdog clears.
- RESP_x always moves to IDLE.
  - x_ready and x_err return to 0.
  - No grant is made in RESP_x, so the requester's req, still high during the ready cycle, is never re-granted.
- mem_ack is ignored in IDLE, RESP_I and RESP_D.
- rst=1 in any state returns every register to its reset value at that edge. An in-flight transaction is abandoned and a later mem_ack is ignored.

## Timing
- Request seen in IDLE at cycle t → mem_req high at t+1.
- mem_ack at cycle a ≥ t+1 → x_ready high at a+1 → IDLE at a+2.
- Minimum cost is 3 cycles per access; the next grant decision is made at a+2.
- Timeout: mem_req is high for exactly TIMEOUT_CYCLES cycles, then x_ready and x_err pulse.
- i_ready and d_ready are never high in the same cycle. mem_req is never high in IDLE, RESP_I or RESP_D.

## Test plan
- **Single fetch.** Drive i_req=1, i_addr=0x100, with mem_ack one cycle after mem_req and mem_rdata=0x00500093. Require:
  - mem_addr=0x100, mem_we=0, mem_type=3'b010.
  - i_ready pulses once with i_rdata=0x00500093 and i_err=0.
  - Total of 3 cycles from request to IDLE.
- **Simultaneous requests.** Drive i_req and d_req in the same cycle, with a load at 0x2000. Require:
  - Data is granted first and d_ready fires.
  - The fetch is granted at the following IDLE.
- **Starvation guard.** With D_MAX_CONSEC=4, hold d_req and i_req continuously. Require:
  - Grant sequence D,D,D,D,I,D,D,D,D,I.
- **Store.** Drive d_we=1, d_type=3'b010, d_addr=0x40, d_wdata=0xCAFEF00D, with mem_ack after 5 cycles. Require:
  - mem_we=1 and mem_wdata=0xCAFEF00D held stable for 5 cycles.
  - d_ready pulses and d_rdata is unchanged.
- **Timeout.** With TIMEOUT_CYCLES=8, drive a fetch and never ack. Require:
  - mem_req is high for 8 cycles.
  - i_ready and i_err pulse together and i_rdata is unchanged.
  - A late mem_ack in IDLE has no effect.
- **Reset mid-operation.** Assert rst for 1 cycle during BUSY_D. Require:
  - All outputs are 0 at the next edge.
  - A mem_ack arriving afterwards produces no d_ready.
